seq_serializer_piso: RTL and testbench
======================================

SEQ_SERIALIZER_PISO -- requirements
Module: seq_serializer_piso

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 serializes MSB first and 0 serializes LSB first.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-006 The block SHALL have port load_valid, input, 1 bit: din holds a word to load.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have port out, output, 1 bit: the serial bit stream fed to the downstream sequence detector.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out carries a data bit this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a word is being shifted.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse after a word's last bit completes.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT.
REQ-013 A load SHALL occur at a rising edge where load_valid=1 and load_ready=1. The load captures din into the shift register, clears the bit counter to 0 and enters SHIFT.
REQ-014 load_ready SHALL be combinational and defined as (state==IDLE) or (state==SHIFT and bit_cnt==WIDTH-1).
REQ-015 load_valid while load_ready=0 SHALL be ignored, and din SHALL NOT be sampled.
REQ-016 In SHIFT, out SHALL be shreg[WIDTH-1] when MSB_FIRST=1 and shreg[0] when MSB_FIRST=0. Each bit SHALL be held for exactly one clock.
REQ-017 At each SHIFT edge without a load, shreg SHALL shift one position toward the output end (zero fill) and bit_cnt SHALL increment by 1.
REQ-018 At the edge ending the bit with bit_cnt==WIDTH-1:
- with a concurrent load, the FSM SHALL stay in SHIFT with the new word (REQ-013);
- otherwise the FSM SHALL go to IDLE.
REQ-019 Latency: for a load at edge k, bit i (i=0..WIDTH-1, in shift order) SHALL appear on out between edges k+i and k+i+1.
REQ-020 Back-to-back loads SHALL produce a gapless stream: no IDLE cycle and out_valid continuously 1.
REQ-021 out SHALL be 0 in IDLE, so the downstream detector sees zeros between words.
REQ-022 out_valid and busy SHALL both equal (state==SHIFT).
REQ-023 done SHALL be a registered signal that is 1 for exactly the one cycle after every edge that ends a last bit (bit_cnt==WIDTH-1), including back-to-back cases.
REQ-024 bit_cnt SHALL be clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-025 Outputs SHALL be glitch-free functions of registered state, except load_ready (REQ-014).

Reset
REQ-026 While rst_n=0, the block SHALL immediately set state=IDLE, shreg=0, bit_cnt=0, out=0, out_valid=0, busy=0 and done=0, with load_ready=1.
REQ-027 Reset asserted mid-word SHALL discard the word with no done pulse. After rst_n deasserts, the first rising edge SHALL accept a load normally.

Verification
REQ-028 WIDTH=4, MSB_FIRST=1, load din=4'b1001 at edge k:
- out = 1,0,0,1 in cycles k..k+3 with out_valid=1;
- done=1 in cycle k+4 only;
- out=0 and load_ready=1 thereafter.
REQ-029 WIDTH=4, MSB_FIRST=0, din=4'b0011 -> out = 1,1,0,0.
REQ-030 WIDTH=4, MSB_FIRST=1, back-to-back loads 4'b1001 then 4'b0010, with the second load at the last-bit edge:
- out = 1,0,0,1,0,0,1,0 with no gap and busy continuously 1;
- done pulses twice, after bits 4 and 8.
REQ-031 load_valid=1 with din=4'hF held in cycles 1-2 of an active word -> ignored; the current word completes unchanged.
REQ-032 rst_n pulled low after the 2nd bit of 4'b1001 -> out=0, busy=0 and no done pulse; a following load of 4'b1001 serializes correctly.
REQ-033 WIDTH=8 default, random words with random load_valid gaps -> a scoreboard-reconstructed stream SHALL match the loaded words bit-exactly.

Source files
------------

// File: rtl/seq_serializer_piso.sv
// rtl/seq_serializer_piso.sv - parallel-in serial-out shifter feeding the sequence detector
// Two-state FSM; a new word may be loaded on the last-bit edge for a gapless stream.
module seq_serializer_piso #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt, shifted;
   logic [CW-1:0]    bit_cnt, cnt_nxt;
   logic             done_q, done_nxt;
   logic             last, load;

   assign last       = (state == SHIFT) && (bit_cnt == LAST);
   assign load_ready = (state == IDLE) || last;
   assign load       = load_valid && load_ready;

   // Shift toward whichever end drives out, filling with zeros.
   assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_cnt <= cnt_nxt;
         done_q  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      cnt_nxt   = bit_cnt;
      done_nxt  = last;
      case (state)
         IDLE: begin
            if (load) begin
               shreg_nxt = din;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (load) begin
               shreg_nxt = din;
               cnt_nxt   = '0;
            end else if (last) begin
               shreg_nxt = shifted;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               shreg_nxt = shifted;
               cnt_nxt   = bit_cnt + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign out_valid = (state == SHIFT);
   assign busy      = (state == SHIFT);
   assign done      = done_q;
   assign out       = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 1'b0;

endmodule

// File: tb/tb_seq_serializer_piso.sv
// tb/tb_seq_serializer_piso.sv - directed and scoreboard bench for seq_serializer_piso
// Three instances: 4-bit MSB-first, 4-bit LSB-first and the 8-bit default.
module tb_seq_serializer_piso;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0] din_a;
   logic       lv_a, lr_a, out_a, ov_a, busy_a, done_a;
   logic [3:0] din_b;
   logic       lv_b, lr_b, out_b, ov_b, busy_b, done_b;
   logic [7:0] din_c;
   logic       lv_c, lr_c, out_c, ov_c, busy_c, done_c;

   int n_checks = 0;
   int n_fail   = 0;

   seq_serializer_piso #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .din(din_a), .load_valid(lv_a), .load_ready(lr_a),
      .out(out_a), .out_valid(ov_a), .busy(busy_a), .done(done_a));

   seq_serializer_piso #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .din(din_b), .load_valid(lv_b), .load_ready(lr_b),
      .out(out_b), .out_valid(ov_b), .busy(busy_b), .done(done_b));

   seq_serializer_piso dut_c (
      .clk(clk), .rst_n(rst_n), .din(din_c), .load_valid(lv_c), .load_ready(lr_c),
      .out(out_c), .out_valid(ov_c), .busy(busy_c), .done(done_c));

   task automatic test_reset();
      rst_n = 1'b0;
      din_a = '0; lv_a = 1'b0; din_b = '0; lv_b = 1'b0; din_c = '0; lv_c = 1'b0;
      #1;
      n_checks++; if (out_a !== 1'b0)  begin n_fail++; $display("FAIL reset_out got %b want 0", out_a); end
      n_checks++; if (ov_a !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov_a); end
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
      n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_a); end
      n_checks++; if (lr_a !== 1'b1)   begin n_fail++; $display("FAIL reset_load_ready got %b want 1", lr_a); end
      n_checks++; if (lr_c !== 1'b1)   begin n_fail++; $display("FAIL reset_load_ready_c got %b want 1", lr_c); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_msb_first();
      logic [3:0] seq;
      seq = 4'b1001;
      @(negedge clk); din_a = 4'b1001; lv_a = 1'b1;
      @(negedge clk); lv_a = 1'b0; din_a = 4'h0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (out_a !== seq[3-i]) begin n_fail++; $display("FAIL msb_out bit %0d got %b want %b", i, out_a, seq[3-i]); end
         n_checks++; if (ov_a !== 1'b1)      begin n_fail++; $display("FAIL msb_out_valid bit %0d got %b want 1", i, ov_a); end
         n_checks++; if (done_a !== 1'b0)    begin n_fail++; $display("FAIL msb_done_early bit %0d got %b want 0", i, done_a); end
         n_checks++; if (lr_a !== (i == 3))  begin n_fail++; $display("FAIL msb_load_ready bit %0d got %b want %b", i, lr_a, (i == 3)); end
         @(negedge clk);
      end
      n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL msb_done got %b want 1", done_a); end
      n_checks++; if (out_a !== 1'b0)  begin n_fail++; $display("FAIL msb_idle_out got %b want 0", out_a); end
      n_checks++; if (ov_a !== 1'b0)   begin n_fail++; $display("FAIL msb_idle_valid got %b want 0", ov_a); end
      n_checks++; if (lr_a !== 1'b1)   begin n_fail++; $display("FAIL msb_idle_ready got %b want 1", lr_a); end
      @(negedge clk);
      n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL msb_done_width got %b want 0", done_a); end
      n_checks++; if (out_a !== 1'b0)  begin n_fail++; $display("FAIL msb_idle_out2 got %b want 0", out_a); end
   endtask

   task automatic test_lsb_first();
      logic [3:0] seq;
      seq = 4'b1100;
      @(negedge clk); din_b = 4'b0011; lv_b = 1'b1;
      @(negedge clk); lv_b = 1'b0; din_b = 4'h0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (out_b !== seq[3-i]) begin n_fail++; $display("FAIL lsb_out bit %0d got %b want %b", i, out_b, seq[3-i]); end
         n_checks++; if (busy_b !== 1'b1)    begin n_fail++; $display("FAIL lsb_busy bit %0d got %b want 1", i, busy_b); end
         @(negedge clk);
      end
      n_checks++; if (done_b !== 1'b1) begin n_fail++; $display("FAIL lsb_done got %b want 1", done_b); end
      n_checks++; if (out_b !== 1'b0)  begin n_fail++; $display("FAIL lsb_idle_out got %b want 0", out_b); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq;
      seq = 8'b1001_0010;
      @(negedge clk); din_a = 4'b1001; lv_a = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         n_checks++; if (out_a !== ((i < 8) ? seq[7-i] : 1'b0)) begin n_fail++; $display("FAIL b2b_out cycle %0d got %b want %b", i, out_a, ((i < 8) ? seq[7-i] : 1'b0)); end
         n_checks++; if (busy_a !== (i < 8)) begin n_fail++; $display("FAIL b2b_busy cycle %0d got %b want %b", i, busy_a, (i < 8)); end
         n_checks++; if (done_a !== (i == 4 || i == 8)) begin n_fail++; $display("FAIL b2b_done cycle %0d got %b want %b", i, done_a, (i == 4 || i == 8)); end
         if (i == 3) begin din_a = 4'b0010; lv_a = 1'b1; end
         else begin lv_a = 1'b0; din_a = 4'h0; end
      end
   endtask

   task automatic test_ignore_busy();
      logic [3:0] seq;
      seq = 4'b1001;
      @(negedge clk); din_a = 4'b1001; lv_a = 1'b1;
      @(negedge clk); din_a = 4'hF; lv_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (out_a !== seq[3-i])   begin n_fail++; $display("FAIL ign_out bit %0d got %b want %b", i, out_a, seq[3-i]); end
         n_checks++; if (lr_a !== (i == 3))    begin n_fail++; $display("FAIL ign_ready bit %0d got %b want %b", i, lr_a, (i == 3)); end
         @(negedge clk);
         if (i >= 1) begin lv_a = 1'b0; din_a = 4'h0; end
      end
      n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL ign_done got %b want 1", done_a); end
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ign_busy_after got %b want 0", busy_a); end
      @(negedge clk);
   endtask

   task automatic test_reset_midword();
      logic [3:0] seq;
      seq = 4'b1001;
      @(negedge clk); din_a = 4'b1001; lv_a = 1'b1;
      @(negedge clk); lv_a = 1'b0; din_a = 4'h0;
      n_checks++; if (out_a !== 1'b1) begin n_fail++; $display("FAIL rst_bit0 got %b want 1", out_a); end
      @(negedge clk);
      n_checks++; if (out_a !== 1'b0) begin n_fail++; $display("FAIL rst_bit1 got %b want 0", out_a); end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (out_a !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_out got %b want 0", out_a); end
      n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy_a); end
      n_checks++; if (lr_a !== 1'b1)   begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", lr_a); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1; din_a = 4'b1001; lv_a = 1'b1;
      n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b want 0", done_a); end
      @(negedge clk); lv_a = 1'b0; din_a = 4'h0;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (out_a !== seq[3-i]) begin n_fail++; $display("FAIL rst_reload bit %0d got %b want %b", i, out_a, seq[3-i]); end
         n_checks++; if (done_a !== 1'b0)    begin n_fail++; $display("FAIL rst_reload_done bit %0d got %b want 0", i, done_a); end
         @(negedge clk);
      end
      n_checks++; if (done_a !== 1'b1) begin n_fail++; $display("FAIL rst_reload_done_end got %b want 1", done_a); end
      @(negedge clk);
   endtask

   task automatic test_random_stream();
      logic q[$];
      logic exp_bit;
      int   rem;
      logic done_exp, ld;
      int   popped;
      rem = 0; done_exp = 1'b0; popped = 0;
      for (int cyc = 0; cyc < 320; cyc++) begin
         @(negedge clk);
         n_checks++; if (ov_c !== (rem > 0)) begin n_fail++; $display("FAIL rnd_valid cycle %0d got %b want %b", cyc, ov_c, (rem > 0)); end
         if (rem > 0) begin
            exp_bit = q.pop_front();
            popped++;
            n_checks++; if (out_c !== exp_bit) begin n_fail++; $display("FAIL rnd_out cycle %0d got %b want %b", cyc, out_c, exp_bit); end
         end else begin
            n_checks++; if (out_c !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_out cycle %0d got %b want 0", cyc, out_c); end
         end
         n_checks++; if (done_c !== done_exp)  begin n_fail++; $display("FAIL rnd_done cycle %0d got %b want %b", cyc, done_c, done_exp); end
         n_checks++; if (lr_c !== (rem <= 1)) begin n_fail++; $display("FAIL rnd_ready cycle %0d got %b want %b", cyc, lr_c, (rem <= 1)); end
         din_c = 8'($urandom);
         lv_c  = (cyc < 300) && ($urandom_range(0, 2) != 0);
         ld    = lv_c && (rem <= 1);
         if (ld) for (int b = 7; b >= 0; b--) q.push_back(din_c[b]);
         done_exp = (rem == 1);
         rem = ld ? 8 : ((rem > 0) ? rem - 1 : 0);
      end
      lv_c = 1'b0;
      n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL rnd_drain left %0d bits want 0", q.size()); end
      n_checks++; if (popped < 100) begin n_fail++; $display("FAIL rnd_coverage bits %0d want >= 100", popped); end
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_back_to_back();
      test_ignore_busy();
      test_reset_midword();
      test_random_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
